// File: rtl/hfrv_mem_arbiter_if.sv
// Request/response bundle for one master of the HF-RISC memory arbiter.
// The master drives the request side; the arbiter drives grant and read return.
interface hfrv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] we;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, addr, wdata, we, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wdata, we, output gnt, rvalid, rdata);
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// Two-master round-robin arbiter with bounded burst lock in front of the
// single-port HF-RISC SRAM; read data is steered back by an owner-tag pipeline.
module hfrv_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hfrv_mem_arbiter_if.slave       m0,
    hfrv_mem_arbiter_if.slave       m1,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state, state_nxt;
    logic [3:0] burst_cnt, burst_nxt, burst_inc;
    logic       last_owner;
    logic       gnt0, gnt1;
    logic       push_vld;
    logic       rv0, rv1;
    logic [DATA_WIDTH-1:0] hold0, hold1;
    logic [MEM_LATENCY:1]  vld_pipe, own_pipe;

    assign burst_inc = (burst_cnt == BURST_LIM) ? burst_cnt : burst_cnt + 4'd1;

    // Grants are held low while reset is asserted so nothing reaches memory.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = IDLE;
        burst_nxt = 4'd0;
        if (reset_n) begin
            if (m0.req && m1.req) begin
                case (state)
                    OWN0:    if (burst_cnt < BURST_LIM) gnt0 = 1'b1; else gnt1 = 1'b1;
                    OWN1:    if (burst_cnt < BURST_LIM) gnt1 = 1'b1; else gnt0 = 1'b1;
                    default: if (last_owner) gnt0 = 1'b1; else gnt1 = 1'b1;
                endcase
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
        if (gnt0) begin
            state_nxt = OWN0;
            burst_nxt = (state == OWN0) ? burst_inc : 4'd0;
        end else if (gnt1) begin
            state_nxt = OWN1;
            burst_nxt = (state == OWN1) ? burst_inc : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_owner <= 1'b1;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (gnt0 || gnt1) last_owner <= gnt1;
        end
    end

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;
    assign mem_en = gnt0 | gnt1;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (gnt0) begin
            mem_addr  = m0.addr;
            mem_wdata = m0.wdata;
            mem_we    = m0.we;
        end else if (gnt1) begin
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
            mem_we    = m1.we;
        end
    end

    // Stage 1 is loaded at acceptance; the last stage lines up with mem_rdata.
    assign push_vld = (gnt0 && m0.we == '0) || (gnt1 && m1.we == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            vld_pipe[1] <= push_vld;
            own_pipe[1] <= gnt1;
            for (int i = 2; i <= MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    assign rv0 = vld_pipe[MEM_LATENCY] & ~own_pipe[MEM_LATENCY];
    assign rv1 = vld_pipe[MEM_LATENCY] &  own_pipe[MEM_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (rv0) hold0 <= mem_rdata;
            if (rv1) hold1 <= mem_rdata;
        end
    end

    // Owner sees memory data on its return cycle; otherwise its last value.
    assign m0.rvalid = rv0;
    assign m1.rvalid = rv1;
    assign m0.rdata  = rv0 ? mem_rdata : hold0;
    assign m1.rdata  = rv1 ? mem_rdata : hold1;
endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench: one arbiter with 1-cycle memory, one with 3-cycle memory,
// each backed by a small SRAM model with the matching read latency.
module tb_hfrv_mem_arbiter;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    hfrv_mem_arbiter_if a0 (), a1 (), b0 (), b1 ();

    logic        men_a, men_b;
    logic [31:0] maddr_a, maddr_b, mwd_a, mwd_b, mrd_a, mrd_b;
    logic [3:0]  mwe_a, mwe_b;

    hfrv_mem_arbiter #(.MEM_LATENCY(1), .MAX_BURST(4)) ua (
        .clk(clk), .reset_n(reset_n), .m0(a0), .m1(a1),
        .mem_en(men_a), .mem_addr(maddr_a), .mem_wdata(mwd_a),
        .mem_we(mwe_a), .mem_rdata(mrd_a));

    hfrv_mem_arbiter #(.MEM_LATENCY(3), .MAX_BURST(4)) ub (
        .clk(clk), .reset_n(reset_n), .m0(b0), .m1(b1),
        .mem_en(men_b), .mem_addr(maddr_b), .mem_wdata(mwd_b),
        .mem_we(mwe_b), .mem_rdata(mrd_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h40)  return 32'h11223344;
        return 32'hA0000000 | a;
    endfunction

    // Memory A: latency 1, byte-writable overlay on top of the fixed pattern.
    logic [31:0]  mema [0:255];
    logic [255:0] wv;
    logic [31:0]  rda, wtmp;
    always @(posedge clk) begin
        if (!reset_n) wv <= '0;
        else if (men_a) begin
            wtmp = wv[maddr_a[9:2]] ? mema[maddr_a[9:2]] : pat(maddr_a);
            if (mwe_a == 4'b0) rda <= wtmp;
            else begin
                for (int i = 0; i < 4; i++)
                    if (mwe_a[i]) wtmp[i*8 +: 8] = mwd_a[i*8 +: 8];
                mema[maddr_a[9:2]] <= wtmp;
                wv[maddr_a[9:2]]   <= 1'b1;
            end
        end
    end
    assign mrd_a = rda;

    // Memory B: read-only pattern, latency 3.
    logic [31:0] rdb1, rdb2, rdb3;
    always @(posedge clk) begin
        if (men_b && mwe_b == 4'b0) rdb1 <= pat(maddr_b);
        rdb2 <= rdb1;
        rdb3 <= rdb2;
    end
    assign mrd_b = rdb3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic rst;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic idle_all;
        a0.req = 0; a1.req = 0; b0.req = 0; b1.req = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        a0.addr = 0; a0.wdata = 0; a0.we = 0;
        a1.addr = 0; a1.wdata = 0; a1.we = 0;
        b0.addr = 0; b0.wdata = 0; b0.we = 0;
        b1.addr = 0; b1.wdata = 0; b1.we = 0;

        // Reset state, with a request pending that must not be granted.
        a0.req = 1; a0.addr = 32'h100;
        mid();
        chk("rst_gnt0", a0.gnt, 0);
        chk("rst_men", men_a, 0);
        chk("rst_maddr", maddr_a, 0);
        chk("rst_rv0", a0.rvalid, 0);
        chk("rst_rdata0", a0.rdata, 0);
        chk("rst_rv1_b", b1.rvalid, 0);
        a0.req = 0;
        step();
        step();
        reset_n = 1'b1;

        // Single read, latency 1.
        a0.req = 1; a0.addr = 32'h100; a0.we = 0;
        mid();
        chk("rd_gnt0", a0.gnt, 1);
        chk("rd_gnt1", a1.gnt, 0);
        chk("rd_men", men_a, 1);
        chk("rd_maddr", maddr_a, 32'h100);
        chk("rd_mwe", mwe_a, 0);
        step();
        a0.req = 0;
        mid();
        chk("rd_rv0", a0.rvalid, 1);
        chk("rd_data0", a0.rdata, 32'hDEADBEEF);
        chk("rd_rv1", a1.rvalid, 0);
        chk("rd_men_idle", men_a, 0);
        step();
        mid();
        chk("rd_rv0_off", a0.rvalid, 0);
        chk("rd_hold0", a0.rdata, 32'hDEADBEEF);

        // Continuous contention from reset: m0 x4, m1 x4, m0 x4.
        step();
        rst();
        a0.req = 1; a0.addr = 32'h10;
        a1.req = 1; a1.addr = 32'h20;
        for (int i = 0; i < 12; i++) begin
            mid();
            chk($sformatf("burst_g0_%0d", i), a0.gnt, ((i / 4) % 2) == 0);
            chk($sformatf("burst_g1_%0d", i), a1.gnt, ((i / 4) % 2) == 1);
            chk($sformatf("burst_men_%0d", i), men_a, 1);
            step();
        end
        idle_all();
        step();
        step();

        // m1 partial write, then m0 reads the same word.
        a1.req = 1; a1.addr = 32'h40; a1.wdata = 32'hAABBCCDD; a1.we = 4'b0011;
        mid();
        chk("wr_gnt1", a1.gnt, 1);
        chk("wr_mwe", mwe_a, 4'b0011);
        chk("wr_mwd", mwd_a, 32'hAABBCCDD);
        chk("wr_maddr", maddr_a, 32'h40);
        step();
        a1.req = 0; a1.we = 0;
        a0.req = 1; a0.addr = 32'h40;
        mid();
        chk("wr_rd_gnt0", a0.gnt, 1);
        chk("wr_rd_mwe", mwe_a, 4'b0000);
        chk("wr_no_rv1", a1.rvalid, 0);
        step();
        a0.req = 0;
        mid();
        chk("wr_rd_rv0", a0.rvalid, 1);
        chk("wr_rd_data", a0.rdata, 32'h1122CCDD);
        chk("wr_rd_rv1", a1.rvalid, 0);
        step();

        // Latency 3, alternating issuers.
        b0.req = 1; b0.addr = 32'h0;
        mid();
        chk("l3_g0_a", b0.gnt, 1);
        step();
        b0.req = 0; b1.req = 1; b1.addr = 32'h4;
        mid();
        chk("l3_g1", b1.gnt, 1);
        step();
        b1.req = 0; b0.req = 1; b0.addr = 32'h8;
        mid();
        chk("l3_g0_b", b0.gnt, 1);
        step();
        b0.req = 0;
        mid();
        chk("l3_c3_rv0", b0.rvalid, 1);
        chk("l3_c3_d0", b0.rdata, 32'hA0000000);
        chk("l3_c3_rv1", b1.rvalid, 0);
        step();
        mid();
        chk("l3_c4_rv1", b1.rvalid, 1);
        chk("l3_c4_d1", b1.rdata, 32'hA0000004);
        chk("l3_c4_rv0", b0.rvalid, 0);
        step();
        mid();
        chk("l3_c5_rv0", b0.rvalid, 1);
        chk("l3_c5_d0", b0.rdata, 32'hA0000008);
        chk("l3_c5_rv1", b1.rvalid, 0);
        step();
        mid();
        chk("l3_c6_rv0", b0.rvalid, 0);
        chk("l3_c6_hold1", b1.rdata, 32'hA0000004);
        step();

        // Reset with two reads in flight (last issuer m0).
        b1.req = 1; b1.addr = 32'hC;
        mid();
        chk("fl_g1", b1.gnt, 1);
        step();
        b1.req = 0; b0.req = 1; b0.addr = 32'h10;
        mid();
        chk("fl_g0", b0.gnt, 1);
        step();
        b0.req = 0;
        reset_n = 1'b0;
        mid();
        chk("fl_rst_rv0", b0.rvalid, 0);
        chk("fl_rst_rv1", b1.rvalid, 0);
        chk("fl_rst_d0", b0.rdata, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("fl_rv0_%0d", i), b0.rvalid, 0);
            chk($sformatf("fl_rv1_%0d", i), b1.rvalid, 0);
            step();
        end
        b0.req = 1; b1.req = 1;
        mid();
        chk("fl_tie_g0", b0.gnt, 1);
        chk("fl_tie_g1", b1.gnt, 0);
        step();
        idle_all();
        step();
        step();
        rst();

        // m0 withdraws during an m1 burst; then the burst limit hands over.
        a1.req = 1; a1.addr = 32'h8;
        mid();
        chk("wd_c0_g1", a1.gnt, 1);
        step();
        a0.req = 1; a0.addr = 32'h100;
        mid();
        chk("wd_c1_g0", a0.gnt, 0);
        chk("wd_c1_g1", a1.gnt, 1);
        step();
        a0.req = 0;
        mid();
        chk("wd_c2_g1", a1.gnt, 1);
        chk("wd_c2_maddr", maddr_a, 32'h8);
        chk("wd_c2_rv1", a1.rvalid, 1);
        chk("wd_c2_rv0", a0.rvalid, 0);
        step();
        mid();
        chk("wd_c3_g1", a1.gnt, 1);
        chk("wd_c3_rv0", a0.rvalid, 0);
        step();
        mid();
        chk("wd_c4_g1", a1.gnt, 1);
        step();
        a0.req = 1;
        mid();
        chk("wd_c5_g0", a0.gnt, 1);
        chk("wd_c5_g1", a1.gnt, 0);
        chk("wd_c5_maddr", maddr_a, 32'h100);
        step();
        a0.req = 0;
        mid();
        chk("wd_c6_g1", a1.gnt, 1);
        chk("wd_c6_rv0", a0.rvalid, 1);
        chk("wd_c6_d0", a0.rdata, 32'hDEADBEEF);
        chk("wd_c6_rv1", a1.rvalid, 0);
        step();
        idle_all();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hfrv_mem_arbiter.md
Name: hfrv_mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port HF-RISC memory between the CPU bus (m0) and a secondary master (m1: DMA/debug loader).
- Sits between dut_top's core memory port and the SRAM model.
- Round-robin arbitration with a bounded burst lock.
- Routes fixed-latency read data back to the issuing master using an owner-tag pipeline.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8.
- MEM_LATENCY, 1, memory read latency in cycles; legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one master while the other requests; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU request valid.
- m0_addr  in  ADDR_WIDTH  CPU address.
- m0_wdata  in  DATA_WIDTH  CPU write data.
- m0_we  in  DATA_WIDTH/8  CPU byte write enables; all-zero means read.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  DATA_WIDTH  CPU read data.
- m1_req / m1_addr / m1_wdata / m1_we / m1_gnt / m1_rvalid / m1_rdata: identical to m0 for the secondary master.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  DATA_WIDTH/8  memory byte write enables.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after a read strobe.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en = 0; rdata outputs, mem_addr, mem_wdata, mem_we = 0; last_owner = m1, so m0 wins the first tie; burst_cnt = 0; tag pipeline cleared.
- Handshake:
  - A transfer occurs on a rising edge where mX_req && mX_gnt.
  - mX_gnt is combinational from the req inputs and registered state.
  - At most one gnt is high per cycle.
  - A master holds req, addr, wdata and we stable until granted; req may drop without a grant (the request is withdrawn, no side effect).
- Memory side:
  - mem_en = m0_gnt | m1_gnt.
  - mem_addr, mem_wdata, mem_we are the granted master's signals, muxed combinationally; 0 when idle.
  - Zero-cycle request-to-memory latency; one access per cycle sustained.
- Arbitration FSM, states IDLE, OWN0, OWN1:
  - IDLE: neither req; no gnt.
  - Single requester: granted immediately.
  - Both requesting from IDLE: grant the master that is not last_owner.
  - In OWNx with both requesting: keep x while burst_cnt < MAX_BURST-1, then switch to the other master and reset burst_cnt to 0.
  - Owner drops req: go to the other master if it requests, else IDLE; burst_cnt reset to 0.
  - burst_cnt increments per accepted beat of the owner and saturates, never wraps.
  - last_owner updates on every accepted beat.
- Read return:
  - Each accepted read pushes tag {valid=1, owner} into a MEM_LATENCY-deep shift register; writes push valid=0.
  - At the output stage, when valid: mX_rvalid = 1 for the tagged owner and mX_rdata = mem_rdata (registered with rvalid).
  - The non-owner's rvalid = 0 and its rdata holds its last value.
  - Back-to-back reads from alternating masters return in issue order, one per cycle, with no bubbles.
- Writes: complete at acceptance; no response.
- Reset mid-operation: in-flight tags are discarded, no rvalid after reset release; FSM returns to IDLE immediately (asynchronous).
- Simultaneous events:
  - A new grant and a read return for the same master in the same cycle are independent; both occur.
  - Burst limit reached in the same cycle the other master drops req: the owner keeps the grant and burst_cnt saturates.

Test Plan:
- Reset release, m0 reads 0x100 with MEM_LATENCY=1, memory holds 0xDEADBEEF → m0_gnt same cycle, mem_en=1, m0_rvalid=1 with 0xDEADBEEF one cycle later; m1_rvalid stays 0.
- Both req continuous from reset, MAX_BURST=4 → grant sequence m0×4, m1×4, m0×4; mem_en never drops.
- m1 write m1_we=4'b0011 to 0x40, then m0 read 0x40 next cycle → mem_we=4'b0011 then 4'b0000; only m0_rvalid asserts.
- MEM_LATENCY=3, alternating reads m0@0x0, m1@0x4, m0@0x8 on consecutive cycles → rvalid m0, m1, m0 on cycles 3, 4, 5 with matching data.
- reset_n asserted with 2 reads in flight → no rvalid afterwards; first post-reset tie granted to m0.
- m0 raises req then drops it while m1 owns the bus mid-burst → no m0_gnt, no memory access for m0; m1 burst continues.
